tdm_mux_tx: RTL and testbench

- Time-division multiplexing transmitter: serialises NCH parallel byte channels onto one output stream in fixed round-robin slots.
- Each frame carries exactly NCH slots, with slot i dedicated to channel i.
- An empty channel's slot carries a fill word.
- It is the transmit end of the slot stream that the team's demux-based channel splitter fans back out. The stream sits between the per-channel sources and the serial link stage.

---
 rtl/tdm_mux_tx.sv | 147 ++++++++++++++
 tb/tb_tdm_mux_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux_tx.sv
// Round-robin TDM transmitter: NCH byte channels share one slot stream, with empty slots carrying FILL.
// Optional build macro TDM_MUX_PARITY_EN adds an even-parity bit registered with each output word.
module tdm_mux_tx #(
  parameter int NCH = 4,
  parameter int W = 8,
  parameter logic [W-1:0] FILL = 8'hA5,
  localparam int CW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CW-1:0]    out_ch,
  output logic             out_sof,
  output logic             out_fill,
  output logic             out_par,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    slot_reg;
  logic             out_valid_reg;
  logic [W-1:0]     out_data_reg;
  logic [CW-1:0]    out_ch_reg;
  logic             out_sof_reg;
  logic             out_fill_reg;
  logic             load;
  logic             free;
  logic             wrap;
  logic [NCH-1:0]   hold_vld;
  logic [NCH*W-1:0] hold_data;
  logic             sel_vld;
  logic [W-1:0]     sel_data;
  logic [W-1:0]     load_data;

  assign free = ~out_valid_reg | out_ready;
  assign wrap = (slot_reg == CW'(NCH - 1));

  // Per-channel holding register; capture has priority so a fill-slot load cannot
  // drop a word arriving in the same cycle.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [W-1:0] data_reg;
    logic         vld_reg;
    logic         cap;
    logic         clr;

    assign cap = in_valid[gi] & ~vld_reg;
    assign clr = load & (slot_reg == CW'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        data_reg <= '0;
        vld_reg  <= 1'b0;
      end else if (cap) begin
        data_reg <= in_data[gi*W +: W];
        vld_reg  <= 1'b1;
      end else if (clr) begin
        vld_reg  <= 1'b0;
      end
    end

    assign hold_vld[gi]         = vld_reg;
    assign hold_data[gi*W +: W] = data_reg;
    assign in_ready[gi]         = ~vld_reg;
  end

  assign sel_vld   = hold_vld[slot_reg];
  assign sel_data  = hold_data[slot_reg*W +: W];
  assign load_data = sel_vld ? sel_data : FILL;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // A stop request at slot 0 exits without loading, so a new frame is never started.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) state_next = RUN;
      end
      RUN: begin
        if (!en && slot_reg == '0) begin
          state_next = IDLE;
        end else begin
          load = free;
          if (!en) state_next = (load && wrap) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        load = free;
        if (load && wrap) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_sof_reg   <= 1'b0;
      out_fill_reg  <= 1'b0;
    end else if (load) begin
      slot_reg      <= wrap ? '0 : slot_reg + 1'b1;
      out_valid_reg <= 1'b1;
      out_data_reg  <= load_data;
      out_ch_reg    <= slot_reg;
      out_sof_reg   <= (slot_reg == '0);
      out_fill_reg  <= ~sel_vld;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

`ifdef TDM_MUX_PARITY_EN
  logic out_par_reg;

  always_ff @(posedge clk) begin
    if (rst)       out_par_reg <= 1'b0;
    else if (load) out_par_reg <= ^load_data;
  end

  assign out_par = out_par_reg;
`else
  assign out_par = 1'b0;
`endif

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign out_sof   = out_sof_reg;
  assign out_fill  = out_fill_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_tdm_mux_tx.sv
// Directed bench for tdm_mux_tx (NCH=4, W=8, FILL=8'hA5) with immediate-assertion checks.
module tb_tdm_mux_tx;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_sof;
  logic        out_fill;
  logic        out_par;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  tdm_mux_tx dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_sof(out_sof), .out_fill(out_fill),
    .out_par(out_par), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  function automatic logic exp_par(input logic [7:0] d);
`ifdef TDM_MUX_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_slot(input string tag, input logic [1:0] ch, input logic [7:0] data,
                          input logic fill, input logic sof);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".ch"},    32'(out_ch),    32'(ch));
    chk({tag, ".data"},  32'(out_data),  32'(data));
    chk({tag, ".fill"},  32'(out_fill),  32'(fill));
    chk({tag, ".sof"},   32'(out_sof),   32'(sof));
    chk({tag, ".par"},   32'(out_par),   32'(exp_par(data)));
    $display("slot %s: ch=%0d data=%h fill=%0d sof=%0d par=%0d", tag, out_ch, out_data,
             out_fill, out_sof, out_par);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.busy",  32'(busy), 32'd0);
    chk("rst.data",  32'(out_data), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'hF);

    // Empty channels: two frames of FILL
    en = 1'b1;
    tick();
    chk("t1.busy",  32'(busy), 32'd1);
    chk("t1.valid0", 32'(out_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_slot($sformatf("t1.%0d", k), 2'(k % 4), 8'hA5, 1'b1, (k % 4) == 0);
    end
    en = 1'b0;
    tick();
    chk("t1.stop.valid", 32'(out_valid), 32'd0);
    chk("t1.stop.busy",  32'(busy), 32'd0);

    // ch0=11, ch2=33
    in_valid = 4'b0101; in_data = 32'h0033_0011;
    tick();
    in_valid = '0;
    chk("t2.ready_full", 32'(in_ready), 32'hA);
    en = 1'b1;
    tick();
    tick(); chk_slot("t2.s0", 2'd0, 8'h11, 1'b0, 1'b1);
    chk("t2.ready_after_s0", 32'(in_ready), 32'hB);
    tick(); chk_slot("t2.s1", 2'd1, 8'hA5, 1'b1, 1'b0);
    tick(); chk_slot("t2.s2", 2'd2, 8'h33, 1'b0, 1'b0);
    chk("t2.ready_after_s2", 32'(in_ready), 32'hF);
    tick(); chk_slot("t2.s3", 2'd3, 8'hA5, 1'b1, 1'b0);

    // Backpressure while ch1=22 sits in slot 1
    in_valid = 4'b0010; in_data = 32'h0000_2200;
    tick(); chk_slot("t3.s0", 2'd0, 8'hA5, 1'b1, 1'b1);
    in_valid = '0;
    tick(); chk_slot("t3.s1", 2'd1, 8'h22, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); chk_slot($sformatf("t3.stall%0d", k), 2'd1, 8'h22, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    tick(); chk_slot("t3.s2", 2'd2, 8'hA5, 1'b1, 1'b0);
    chk("t3.ready", 32'(in_ready), 32'hF);
    tick(); chk_slot("t3.s3", 2'd3, 8'hA5, 1'b1, 1'b0);
    tick(); chk_slot("t3.n0", 2'd0, 8'hA5, 1'b1, 1'b1);
    tick(); chk_slot("t3.n1", 2'd1, 8'hA5, 1'b1, 1'b0);

    // Drop en while slot 2 loads
    en = 1'b0;
    tick(); chk_slot("t4.s2", 2'd2, 8'hA5, 1'b1, 1'b0);
    chk("t4.busy_s2", 32'(busy), 32'd1);
    tick(); chk_slot("t4.s3", 2'd3, 8'hA5, 1'b1, 1'b0);
    chk("t4.busy_s3", 32'(busy), 32'd0);
    tick(); chk("t4.idle.valid", 32'(out_valid), 32'd0);
    tick(); chk("t4.idle.valid2", 32'(out_valid), 32'd0);
    chk("t4.idle.busy", 32'(busy), 32'd0);

    // Reset during slot 1 while ch3 holds 77
    in_valid = 4'b1000; in_data = 32'h7700_0000;
    tick();
    in_valid = '0;
    chk("t5.ready_held", 32'(in_ready), 32'h7);
    en = 1'b1;
    tick();
    tick(); chk_slot("t5.s0", 2'd0, 8'hA5, 1'b1, 1'b1);
    tick(); chk_slot("t5.s1", 2'd1, 8'hA5, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk("t5.rst.valid", 32'(out_valid), 32'd0);
    chk("t5.rst.data",  32'(out_data), 32'd0);
    chk("t5.rst.ch",    32'(out_ch), 32'd0);
    chk("t5.rst.sof",   32'(out_sof), 32'd0);
    chk("t5.rst.fill",  32'(out_fill), 32'd0);
    chk("t5.rst.par",   32'(out_par), 32'd0);
    chk("t5.rst.busy",  32'(busy), 32'd0);
    chk("t5.rst.ready", 32'(in_ready), 32'hF);
    tick();
    chk("t5.rst_en_ignored", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    tick(); chk_slot("t5.r0", 2'd0, 8'hA5, 1'b1, 1'b1);
    tick(); chk_slot("t5.r1", 2'd1, 8'hA5, 1'b1, 1'b0);
    tick(); chk_slot("t5.r2", 2'd2, 8'hA5, 1'b1, 1'b0);
    en = 1'b0;
    tick(); chk_slot("t5.r3", 2'd3, 8'hA5, 1'b1, 1'b0);
    tick(); chk("t5.end.valid", 32'(out_valid), 32'd0);

    // Parity: ch1=07 has odd weight, FILL has even weight
    in_valid = 4'b0010; in_data = 32'h0000_0700;
    tick();
    in_valid = '0;
    en = 1'b1;
    tick();
    tick(); chk_slot("t6.s0", 2'd0, 8'hA5, 1'b1, 1'b1);
    tick(); chk_slot("t6.s1", 2'd1, 8'h07, 1'b0, 1'b0);
`ifdef TDM_MUX_PARITY_EN
    chk("t6.par1", 32'(out_par), 32'd1);
`else
    chk("t6.par1", 32'(out_par), 32'd0);
`endif
    en = 1'b0;
    tick(); chk_slot("t6.s2", 2'd2, 8'hA5, 1'b1, 1'b0);
    tick(); chk_slot("t6.s3", 2'd3, 8'hA5, 1'b1, 1'b0);
    tick(); chk("t6.end.valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
